// File: rtl/sv_mem_pkg.sv
// sv_mem_pkg: shared FSM type and default sizing for the support-vector memory controller
package sv_mem_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_BUF_DEPTH  = 4;
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction
endpackage

// File: rtl/sv_mem_ctrl_if.sv
// sv_mem_ctrl_if: command, load-stream and fetch-stream handshakes of the support-vector controller
interface sv_mem_ctrl_if #(
    parameter int DATA_WIDTH = sv_mem_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = sv_mem_pkg::DEF_ADDR_WIDTH
);
    logic cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [sv_mem_pkg::len_width(ADDR_WIDTH)-1:0] cmd_len;
    logic wr_valid, wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic rd_valid, rd_ready, rd_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic busy, done;
    modport master(
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done
    );
    modport slave(
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done
    );
endinterface

// File: rtl/sv_rd_buf.sv
// sv_rd_buf: synchronous read-return FIFO carrying each word with its burst-last flag
module sv_rd_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         push_last,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic                         head_last,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    assign empty = count == '0;
    assign {head_last, head_data} = mem[rptr];
    // Storage write, pointer wrap and occupancy; push+pop on a full buffer reuses the slot being vacated
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {push_last, push_data};
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
            if (pop) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
            count <= count + $bits(count)'(push) - $bits(count)'(pop);
        end
    end
endmodule

// File: rtl/sv_mem_ctrl.sv
// sv_mem_ctrl: support-vector RAM initiator with burst load and backpressured burst fetch
module sv_mem_ctrl
    import sv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sv_mem_ctrl_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);
    localparam int LW = len_width(ADDR_WIDTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] cur, base_addr;
    logic [LW-1:0] rem, base_rem;
    logic [DATA_WIDTH-1:0] drv;
    logic [CW-1:0] count;
    logic p1, p2, l1, l2, empty, head_last, accept, wr_fire, issue, step, pop;
    assign mem_data = mem_we ? drv : 'z;
    assign bus.rd_valid = !empty;
    assign bus.rd_last = head_last && !empty;
    // Handshake strobes; a fetch issues its first read on the command edge itself
    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.wr_ready  = state == WRITE && rem != '0;
        bus.busy      = state != IDLE;
        accept    = bus.cmd_valid && state == IDLE;
        wr_fire   = bus.wr_valid && bus.wr_ready;
        base_addr = state == IDLE ? bus.cmd_addr : cur;
        base_rem  = state == IDLE ? bus.cmd_len : rem;
        issue     = base_rem != '0 && (accept ? !bus.cmd_write
                    : state == READ && int'(count) + int'(p1) + int'(p2) < BUF_DEPTH);
        step      = issue || wr_fire;
        pop       = bus.rd_valid && bus.rd_ready;
    end
    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = bus.cmd_len == '0 ? DONE : bus.cmd_write ? WRITE : READ;
            WRITE:   state_n = wr_fire && rem == LW'(1) ? DONE : WRITE;
            READ:    state_n = rem == '0 ? DRAIN : READ;
            DRAIN:   state_n = !p1 && !p2 && empty ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    // Address/count tracking, registered RAM strobes, read pipeline flags and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= '0;
            rem      <= '0;
            drv      <= '0;
            mem_addr <= '0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            p1       <= 1'b0;
            p2       <= 1'b0;
            l1       <= 1'b0;
            l2       <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            if (accept || step) begin
                cur <= base_addr + ADDR_WIDTH'(step);
                rem <= base_rem - LW'(step);
            end
            if (step) mem_addr <= base_addr;
            if (wr_fire) drv <= bus.wr_data;
            mem_cs   <= wr_fire || state_n == READ || state_n == DRAIN;
            mem_we   <= wr_fire;
            mem_oe   <= state_n == READ || state_n == DRAIN;
            p1       <= issue;
            p2       <= p1;
            l1       <= issue && base_rem == LW'(1);
            l2       <= l1;
            bus.done <= state == DONE;
        end
    end
    sv_rd_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (p2),
        .pop       (pop),
        .push_data (mem_data),
        .push_last (l2),
        .head_data (bus.rd_data),
        .head_last (head_last),
        .count     (count),
        .empty     (empty)
    );
endmodule

// File: tb/tb_sv_mem_ctrl.sv
// tb_sv_mem_ctrl: directed bench for sv_mem_ctrl with a synchronous RAM model and a shadow copy of loaded words
module tb_sv_mem_ctrl;
    import sv_mem_pkg::*;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int LW = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sv_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    logic [AW-1:0] mem_addr;
    logic mem_cs, mem_we, mem_oe;
    wire [DW-1:0] mem_data;

    sv_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(DEF_BUF_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_data (mem_data)
    );

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] ram_q;
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 'z;
    // Synchronous RAM: write commits at the edge closing a strobe cycle, read data registered one edge after address
    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
        if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        total++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.wr_ready, bus.rd_valid, bus.rd_last, mem_cs, mem_we, mem_oe} !== 9'b1_0000_0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want %b",
                {bus.cmd_ready, bus.busy, bus.done, bus.wr_ready, bus.rd_valid, bus.rd_last, mem_cs, mem_we, mem_oe}, 9'b1_0000_0000);
        end
        total++;
        if (mem_addr !== '0) begin
            bad++;
            $display("FAIL reset_addr: got %h want 0", mem_addr);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_idle: got ready/busy %b want 10", {bus.cmd_ready, bus.busy});
        end
    endtask

    task automatic test_load(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base, input string name);
        logic [AW-1:0] a;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LW'(len);
        bus.wr_valid  = 1'b1;
        bus.wr_data   = base;
        tick();
        bus.cmd_valid = 1'b0;
        total++;
        if ({bus.wr_ready, mem_we} !== 2'b10) begin
            bad++;
            $display("FAIL %s_enter: got wr_ready/we %b want 10", name, {bus.wr_ready, mem_we});
        end
        for (int i = 0; i < len; i++) begin
            tick();
            a = addr + AW'(i);
            shadow[a] = base + DW'(i);
            total++;
            if ({mem_cs, mem_we, mem_addr, mem_data} !== {2'b11, a, base + DW'(i)}) begin
                bad++;
                $display("FAIL %s_strobe%0d: got cs=%b we=%b addr=%0d data=%h want cs=1 we=1 addr=%0d data=%h",
                    name, i, mem_cs, mem_we, mem_addr, mem_data, a, base + DW'(i));
            end
            bus.wr_data = base + DW'(i + 1);
        end
        bus.wr_valid = 1'b0;
        tick();
        total++;
        if ({bus.done, mem_cs, mem_we} !== 3'b100) begin
            bad++;
            $display("FAIL %s_done: got done/cs/we %b want 100", name, {bus.done, mem_cs, mem_we});
        end
        tick();
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL %s_done_pulse: got done/busy %b want 00", name, {bus.done, bus.busy});
        end
        for (int i = 0; i < len; i++) begin
            a = addr + AW'(i);
            total++;
            if (ram[a] !== shadow[a]) begin
                bad++;
                $display("FAIL %s_ram%0d: got %h want %h", name, a, ram[a], shadow[a]);
            end
        end
    endtask

    task automatic test_fetch(input logic [AW-1:0] addr, input int len, input logic [3:0] pat, input bit chk_lat, input string name);
        int n = 0;
        int cyc = 1;
        int first = -1;
        int first_pop = -1;
        int last_pop = -1;
        int dones = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LW'(len);
        bus.rd_ready  = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        while (cyc <= 600) begin
            if (bus.done) begin
                dones++;
                total++;
                if (n !== len) begin
                    bad++;
                    $display("FAIL %s_early_done: got %0d words at done want %0d", name, n, len);
                end
            end
            if (stalled) begin
                total++;
                if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, n == len - 1, held}) begin
                    bad++;
                    $display("FAIL %s_stall%0d: got valid=%b last=%b data=%h want valid=1 last=%b data=%h",
                        name, n, bus.rd_valid, bus.rd_last, bus.rd_data, n == len - 1, held);
                end
            end
            if (bus.rd_valid && first < 0) first = cyc;
            bus.rd_ready = pat[cyc % 4];
            stalled = bus.rd_valid && !bus.rd_ready;
            held = bus.rd_data;
            if (bus.rd_valid && bus.rd_ready) begin
                exp = shadow[addr + AW'(n)];
                total++;
                if ({bus.rd_last, bus.rd_data} !== {n == len - 1, exp}) begin
                    bad++;
                    $display("FAIL %s_word%0d: got last=%b data=%h want last=%b data=%h",
                        name, n, bus.rd_last, bus.rd_data, n == len - 1, exp);
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n++;
            end
            if (dones > 0 && n >= len) break;
            tick();
            cyc++;
        end
        bus.rd_ready = 1'b0;
        total++;
        if (n !== len || dones !== 1) begin
            bad++;
            $display("FAIL %s_count: got words=%0d dones=%0d want words=%0d dones=1", name, n, dones, len);
        end
        if (chk_lat) begin
            total++;
            if (first !== 3) begin
                bad++;
                $display("FAIL %s_latency: got first valid at cycle %0d want 3", name, first);
            end
            total++;
            if (last_pop - first_pop !== len - 1) begin
                bad++;
                $display("FAIL %s_b2b: got span %0d want %0d", name, last_pop - first_pop, len - 1);
            end
        end
        tick();
        total++;
        if ({bus.done, bus.rd_valid, bus.busy, mem_cs} !== 4'b0000) begin
            bad++;
            $display("FAIL %s_end: got done/valid/busy/cs %b want 0000", name, {bus.done, bus.rd_valid, bus.busy, mem_cs});
        end
    endtask

    task automatic test_zero_len(input logic write);
        int dones = 0;
        int at = -1;
        logic cs_seen = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = write;
        bus.cmd_addr  = AW'(17);
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 32'hDEAD_BEEF;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (mem_cs || mem_we || mem_oe) cs_seen = 1'b1;
            if (bus.done) begin
                dones++;
                at = c;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        total++;
        if (cs_seen !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_w%0b_cs: got mem activity %b want 0", write, cs_seen);
        end
        total++;
        if (dones !== 1 || at !== 2) begin
            bad++;
            $display("FAIL zero_len_w%0b_done: got %0d pulses at cycle %0d want 1 at cycle 2", write, dones, at);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int c = 0;
        int dones = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = LW'(8);
        bus.rd_ready  = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        while (n < 2 && c < 50) begin
            if (bus.rd_valid && bus.rd_ready) n++;
            tick();
            c++;
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL rst_mid_wait: got %0d words want 2", n);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({mem_cs, mem_we, mem_oe, bus.rd_valid, bus.rd_last, bus.done, bus.busy} !== 7'b0) begin
            bad++;
            $display("FAIL rst_mid_state: got cs/we/oe/valid/last/done/busy %b want 0000000",
                {mem_cs, mem_we, mem_oe, bus.rd_valid, bus.rd_last, bus.done, bus.busy});
        end
        rst = 1'b0;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dones++;
            tick();
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL rst_mid_done: got %0d done pulses want 0", dones);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load(AW'(0), 4, 32'hA0, "load4");
        test_fetch(AW'(0), 4, 4'b1111, 1'b1, "fetch4");
        test_load(AW'(8), 8, 32'hB0, "load8");
        test_fetch(AW'(8), 8, 4'b1001, 1'b0, "fetch_bp");
        test_fetch(AW'(8), 8, 4'b0001, 1'b0, "fetch_slow");
        test_load(AW'(62), 4, 32'h11, "load_wrap");
        test_fetch(AW'(62), 4, 4'b1111, 1'b1, "fetch_wrap");
        test_zero_len(1'b1);
        test_zero_len(1'b0);
        test_load(AW'(0), 64, 32'h1000, "load64");
        test_fetch(AW'(5), 64, 4'b1111, 1'b1, "fetch64");
        test_reset_mid();
        test_fetch(AW'(30), 2, 4'b1111, 1'b1, "fetch_after_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
